// File: rtl/pit_table_v2.sv
// Pending Interest Table: direct-mapped slots with full-prefix tags,
// interest aggregation, data satisfaction and tick-based entry expiry.
module pit_table_v2 #(
    parameter int PREFIX_W    = 64,
    parameter int META_W      = 8,
    parameter int LEN_W       = 6,
    parameter int IDX_W       = 6,
    parameter int ADDR_W      = 10,
    parameter int BLOCK_SIZE  = 1,
    parameter int LIFE_W      = 4,
    parameter int LIFETIME    = 8,
    parameter int TICK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                int_valid,
    input  logic [PREFIX_W-1:0] int_prefix,
    input  logic [LEN_W-1:0]    int_len,
    output logic                int_ready,
    input  logic                dat_valid,
    input  logic [PREFIX_W-1:0] dat_prefix,
    input  logic [META_W-1:0]   dat_meta,
    output logic                dat_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [1:0]          resp_kind,
    output logic [ADDR_W-1:0]   resp_addr,
    output logic [META_W-1:0]   resp_meta,
    output logic [IDX_W:0]      occupancy
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int NCH   = (PREFIX_W + IDX_W - 1) / IDX_W;
    localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [1:0] K_NEW = 2'b00;
    localparam logic [1:0] K_AGG = 2'b01;
    localparam logic [1:0] K_SAT = 2'b10;
    localparam logic [1:0] K_REJ = 2'b11;

    typedef enum logic [1:0] {IDLE, HASH, LOOKUP, RESP} state_t;

    state_t              state;
    logic                rdy;
    logic                is_dat;
    logic [PREFIX_W-1:0] pfx;
    logic [META_W-1:0]   meta;
    logic [IDX_W-1:0]    idx;
    logic [ADDR_W-1:0]   ptr;
    logic [TW-1:0]       tick_cnt;
    logic                tick;

    logic [DEPTH-1:0]    valid;
    logic [PREFIX_W-1:0] tag  [DEPTH];
    logic [ADDR_W-1:0]   addr [DEPTH];
    logic [LIFE_W-1:0]   life [DEPTH];

    logic [NCH*IDX_W-1:0] padded;
    logic [IDX_W-1:0]     hash;
    logic [META_W-1:0]    int_meta;
    logic                 hit;
    logic                 alloc;
    logic                 refresh;
    logic                 free;
    logic [1:0]           kind;
    logic [ADDR_W-1:0]    out_addr;
    logic [IDX_W:0]       count;

    assign int_ready = rdy;
    assign dat_ready = rdy;
    assign occupancy = count;
    assign tick      = (tick_cnt == TW'(TICK_CYCLES - 1));

    always_comb begin
        padded = '0;
        padded[PREFIX_W-1:0] = pfx;
        hash = '0;
        for (int i = 0; i < NCH; i++) begin
            hash = hash ^ padded[i*IDX_W +: IDX_W];
        end
    end

    always_comb begin
        int_meta = '0;
        int_meta[LEN_W+1:0] = {2'b01, int_len};
    end

    // Lookup reads the registered slot, i.e. state from before this cycle's tick.
    always_comb begin
        hit     = valid[idx] && (tag[idx] == pfx);
        alloc   = !is_dat && !valid[idx];
        refresh = !is_dat && hit;
        free    = is_dat && hit;
        if (alloc) begin
            kind     = K_NEW;
            out_addr = ptr;
        end else if (refresh) begin
            kind     = K_AGG;
            out_addr = addr[idx];
        end else if (free) begin
            kind     = K_SAT;
            out_addr = addr[idx];
        end else begin
            kind     = K_REJ;
            out_addr = '0;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + (IDX_W+1)'(valid[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rdy        <= 1'b0;
            is_dat     <= 1'b0;
            pfx        <= '0;
            meta       <= '0;
            idx        <= '0;
            ptr        <= '0;
            tick_cnt   <= '0;
            valid      <= '0;
            resp_valid <= 1'b0;
            resp_kind  <= '0;
            resp_addr  <= '0;
            resp_meta  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i] && life[i] == LIFE_W'(1)) begin
                        valid[i] <= 1'b0;
                    end
                end
            end
            unique case (state)
                IDLE: begin
                    if (!rdy) begin
                        rdy <= 1'b1;
                    end else if (dat_valid) begin
                        is_dat <= 1'b1;
                        pfx    <= dat_prefix;
                        meta   <= dat_meta;
                        rdy    <= 1'b0;
                        state  <= HASH;
                    end else if (int_valid) begin
                        is_dat <= 1'b0;
                        pfx    <= int_prefix;
                        meta   <= int_meta;
                        rdy    <= 1'b0;
                        state  <= HASH;
                    end
                end
                HASH: begin
                    idx   <= hash;
                    state <= LOOKUP;
                end
                LOOKUP: begin
                    // Placed after the aging loop so a same-slot write overrides expiry.
                    if (alloc || refresh) begin
                        valid[idx] <= 1'b1;
                    end
                    if (free) begin
                        valid[idx] <= 1'b0;
                    end
                    if (alloc) begin
                        ptr <= ptr + ADDR_W'(BLOCK_SIZE);
                    end
                    resp_valid <= 1'b1;
                    resp_kind  <= kind;
                    resp_addr  <= out_addr;
                    resp_meta  <= meta;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rdy        <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tick) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && life[i] != '0) begin
                    life[i] <= life[i] - LIFE_W'(1);
                end
            end
        end
        if (state == LOOKUP && (alloc || refresh)) begin
            life[idx] <= LIFE_W'(LIFETIME);
            if (alloc) begin
                tag[idx]  <= pfx;
                addr[idx] <= ptr;
            end
        end
    end

endmodule

// File: doc/pit_table_v2.md
Name: pit_table_v2

Overview:
- Parametrised next-generation Pending Interest Table for the NDN router.
- Interests arrive from the SPI side; data arrives from the FIB side. Each request is hashed to a direct-mapped slot.
- Interest handling: allocate a new entry, aggregate a duplicate, or reject on a hash collision.
- Data handling: satisfy and free the matching entry, or reject unrequested data.
- Additions: full-prefix tag match, valid/ready handshakes, entry lifetime expiry and an occupancy count.

Parameters:
- PREFIX_W, 64, prefix width in bits.
- META_W, 8, metadata width; must be ≥ LEN_W+2.
- LEN_W, 6, interest length width.
- IDX_W, 6, log2 of table depth (2^IDX_W slots).
- ADDR_W, 10, content-store block address width.
- BLOCK_SIZE, 1, address increment per allocation.
- LIFE_W, 4, per-entry lifetime counter width.
- LIFETIME, 8, ticks an entry lives after allocate/refresh; range 1..2^LIFE_W-1.
- TICK_CYCLES, 16, clk cycles per lifetime tick.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- int_valid  in  1  interest request.
- int_prefix  in  PREFIX_W  interest name prefix.
- int_len  in  LEN_W  interest length.
- int_ready  out  1  interest accepted when int_valid && int_ready.
- dat_valid  in  1  data request.
- dat_prefix  in  PREFIX_W  data name prefix.
- dat_meta  in  META_W  data metadata.
- dat_ready  out  1  data accepted when dat_valid && dat_ready.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_kind  out  2  00 NEW, 01 AGG, 10 SAT, 11 REJ.
- resp_addr  out  ADDR_W  block address of the entry; 0 on REJ.
- resp_meta  out  META_W  {2'b01, int_len} (zero-extended) for interests; dat_meta for data.
- occupancy  out  IDX_W+1  number of valid slots.

Behaviour:
- Reset (async, rst=1): all outputs 0; all slots invalid; allocation pointer 0; tick counter 0; FSM to IDLE. Reset mid-transaction drops that transaction; no response is issued.
- Hash: XOR of consecutive IDX_W-bit chunks of the prefix, LSB-aligned; the top chunk is zero-padded.
- Slot contents: valid, full prefix tag, ADDR_W address, LIFE_W remaining life.
- FSM IDLE:
  - dat_ready = int_ready = 1 only in IDLE.
  - If dat_valid, accept data (data has priority); else if int_valid, accept interest.
  - Latch prefix/meta and go to HASH.
  - A source not accepted must hold its request; it is accepted on a later IDLE.
- FSM HASH: register the hash index; go to LOOKUP.
- FSM LOOKUP: read the slot, decide, write back; go to RESP.
  - Interest, slot invalid: allocate valid=1, tag=prefix, addr=alloc ptr, life=LIFETIME. Then alloc ptr += BLOCK_SIZE (mod 2^ADDR_W); occupancy +1. kind NEW.
  - Interest, valid and tag match: life=LIFETIME; kind AGG; addr = stored addr.
  - Interest, valid and tag mismatch: no change; kind REJ (collision).
  - Data, valid and tag match: kind SAT; addr = stored addr; slot invalidated; occupancy -1.
  - Data, otherwise: kind REJ; no change.
- FSM RESP: resp_valid=1 with outputs stable until resp_ready. Return to IDLE in the cycle after the handshake.
  - Accept in cycle T gives resp_valid at T+3 (resp_valid first samples high at the clk edge ending cycle T+3).
  - resp_ready held high gives a throughput of one request per 4 cycles.
- Aging:
  - The tick counter counts 0..TICK_CYCLES-1 continuously, independent of FSM state.
  - On wrap, every valid slot with life>0 decrements.
  - A slot whose life goes to 0 is invalidated and occupancy decrements; multiple expiries in one cycle subtract their total.
  - Expiry and a LOOKUP write to the same slot in the same cycle: the LOOKUP write wins and occupancy is adjusted once, consistently.
  - LOOKUP sees slot state from before that cycle's tick.
- Freed addresses are not reused; the allocation pointer only advances.
- Table full: no global-full rejection, since the table is direct-mapped. Occupancy saturates naturally at 2^IDX_W.

Test Plan:
- Reset then interest prefix=0x1, len=5, resp_ready=1 → at T+3: kind=00, addr=0, meta=0x45, occupancy=1. Second new prefix 0x80 (index 2) → kind=00, addr=1, occupancy=2.
- Repeat interest 0x1 → kind=01, addr=0, occupancy unchanged. Interest 0x1041 (same index 1, different tag) → kind=11, addr=0.
- Data prefix=0x1, meta=0xA3 → kind=10, addr=0, meta=0xA3, occupancy -1. Data 0x1 again → kind=11.
- dat_valid and int_valid asserted in the same IDLE cycle → data handled first. Interest held, accepted on the next IDLE, responded 4 cycles later (both responses correct).
- LIFETIME=2, TICK_CYCLES=4: allocate 0x1, no refresh → slot invalid and occupancy 0 after the second tick. Interest 0x1 afterwards → kind=00 with addr=1 (pointer not reused).
- resp_ready=0 for 10 cycles → resp_valid and resp_* stable, int_ready/dat_ready=0. Assert rst mid-LOOKUP → all outputs 0 immediately, occupancy 0, no response after release.
